async_evt_sync: RTL

Multi-channel asynchronous event synchronizer. Each channel latches an edge on an unclocked input, carries it across into the `bclk` domain through a synchronizer chain of configurable depth, and emits a single-cycle pulse. It also keeps a sticky pending/overflow status with an acknowledge, and an optional per-channel event counter. It sits at the boundary between unclocked sources (pads, comparators, foreign-domain strobes) and `bclk` control logic.

---
 rtl/async_evt_pkg.sv | 43 ++++
 rtl/async_evt_chan.sv | 128 ++++++++++++
 rtl/async_evt_sync.sv | 71 +++++++
 3 files changed

// File: rtl/async_evt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : async_evt_pkg
//  Description : Shared constants and helpers for the asynchronous event
//                synchronizer (async_evt_sync / async_evt_chan).
//                - ASYNC_EVT_MIN_SYNC : minimum legal synchronizer depth
//                - EDGE_RISE/EDGE_FALL: per-channel active-edge encodings
//                - evt_cnt_sat()      : saturating event-counter update
//  Revision    : 1.0 - initial release
// ============================================================================
package async_evt_pkg;

    localparam int ASYNC_EVT_MIN_SYNC = 2;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    // Widest counter evt_cnt_sat() can operate on; channels zero-extend
    // their counter into this width and truncate the result back.
    localparam int ASYNC_EVT_CNT_MAX_W = 32;

    // Next counter value. A clear coincident with an increment counts the
    // new event, so the result is 1 rather than 0. Increments stop at
    // cnt_max (the channel's all-ones value).
    function automatic logic [ASYNC_EVT_CNT_MAX_W-1:0] evt_cnt_sat(
        input logic [ASYNC_EVT_CNT_MAX_W-1:0] cnt,
        input logic                           inc,
        input logic                           clr,
        input logic [ASYNC_EVT_CNT_MAX_W-1:0] cnt_max
    );
        logic [ASYNC_EVT_CNT_MAX_W-1:0] nxt;
        if (clr) begin
            nxt = {{(ASYNC_EVT_CNT_MAX_W-1){1'b0}}, inc};
        end else if (inc && (cnt < cnt_max)) begin
            nxt = cnt + {{(ASYNC_EVT_CNT_MAX_W-1){1'b0}}, 1'b1};
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

endpackage : async_evt_pkg
`default_nettype wire

// File: rtl/async_evt_chan.sv
`default_nettype none
// ============================================================================
//  Module      : async_evt_chan
//  Description : One event-synchronizer channel: edge capture flop clocked by
//                the unclocked input, SYNC_STAGES-deep bclk synchronizer,
//                single-cycle pulse generator, sticky pending/overflow flags
//                and (with ASYNC_EVT_CNT_EN) a saturating event counter.
//  Ports       : bclk_i       - system clock
//                async_rst_i  - asynchronous active-high reset
//                async_in_i   - unclocked event input
//                ack_i        - clears pend/ovf (bclk-sampled)
//                cnt_clr_i    - counter clear        (ASYNC_EVT_CNT_EN only)
//                evt_cnt_o    - saturating count     (ASYNC_EVT_CNT_EN only)
//                evt_pulse_o  - one-cycle event strobe
//                evt_pend_o   - sticky event pending
//                evt_ovf_o    - sticky overflow
//  Macro       : ASYNC_EVT_CNT_EN enables the event counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module async_evt_chan
    import async_evt_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic EDGE_SEL    = EDGE_RISE,
    parameter int   CNT_W       = 8
) (
    input  logic             bclk_i,
    input  logic             async_rst_i,
    input  logic             async_in_i,
    input  logic             ack_i,
`ifdef ASYNC_EVT_CNT_EN
    input  logic             cnt_clr_i,
    output logic [CNT_W-1:0] evt_cnt_o,
`endif
    output logic             evt_pulse_o,
    output logic             evt_pend_o,
    output logic             evt_ovf_o
);

    if ((CNT_W < 1) || (CNT_W > ASYNC_EVT_CNT_MAX_W)) begin : g_bad_cnt_w
        $error("async_evt_chan: CNT_W out of range");
    end

    logic                   w_in_eff;
    logic                   w_cap_clr;
    logic                   w_pulse;
    logic                   cap_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   pend_q;
    logic                   pend_d;
    logic                   ovf_q;
    logic                   ovf_d;

    // Static inversion so the capture flop always triggers on a rising edge.
    assign w_in_eff = async_in_i ^ (EDGE_SEL == EDGE_FALL);

    // The capture flop is only released once the event has reached the last
    // sync stage and the input is back at its inactive level; this makes a
    // held-active input yield exactly one event.
    assign w_cap_clr = async_rst_i | (~w_in_eff & sync_q[SYNC_STAGES-1]);

    always_ff @(posedge w_in_eff or posedge w_cap_clr) begin
        if (w_cap_clr) begin
            cap_q <= 1'b0;
        end else begin
            cap_q <= 1'b1;
        end
    end

    always_ff @(posedge bclk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cap_q};
            dly_q  <= sync_q[SYNC_STAGES-1];
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign w_pulse = sync_q[SYNC_STAGES-1] & ~dly_q;

    // Acknowledge wins, but an event landing in the ack cycle is kept pending.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (ack_i) begin
            pend_d = w_pulse;
            ovf_d  = 1'b0;
        end else if (w_pulse) begin
            if (pend_q) begin
                ovf_d = 1'b1;
            end
            pend_d = 1'b1;
        end
    end

    assign evt_pulse_o = w_pulse;
    assign evt_pend_o  = pend_q;
    assign evt_ovf_o   = ovf_q;

`ifdef ASYNC_EVT_CNT_EN
    localparam logic [ASYNC_EVT_CNT_MAX_W-1:0] c_cnt_max =
        ASYNC_EVT_CNT_MAX_W'((64'd1 << CNT_W) - 64'd1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_d = CNT_W'(evt_cnt_sat(ASYNC_EVT_CNT_MAX_W'(cnt_q), w_pulse,
                                      cnt_clr_i, c_cnt_max));

    always_ff @(posedge bclk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign evt_cnt_o = cnt_q;
`endif

endmodule : async_evt_chan
`default_nettype wire

// File: rtl/async_evt_sync.sv
`default_nettype none
// ============================================================================
//  Module      : async_evt_sync
//  Description : Multi-channel asynchronous event synchronizer. Each channel
//                captures an edge on an unclocked input, carries it into the
//                bclk domain and reports it as a one-cycle pulse plus sticky
//                pending/overflow status (and optional saturating counter).
//  Ports       : bclk       - system clock
//                async_rst  - asynchronous active-high reset
//                async_in   - [CH] unclocked event inputs
//                ack        - [CH] clear of evt_pend/evt_ovf
//                cnt_clr    - [CH] counter clear          (ASYNC_EVT_CNT_EN)
//                evt_pulse  - [CH] one-cycle event strobe
//                evt_pend   - [CH] sticky pending flag
//                evt_ovf    - [CH] sticky overflow flag
//                evt_cnt    - [CH*CNT_W] counts, ch i at [i*CNT_W +: CNT_W]
//                                                          (ASYNC_EVT_CNT_EN)
//  Macro       : ASYNC_EVT_CNT_EN adds cnt_clr, evt_cnt and the counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module async_evt_sync
    import async_evt_pkg::*;
#(
    parameter int            CH          = 4,
    parameter int            SYNC_STAGES = 2,
    parameter logic [CH-1:0] EDGE_SEL    = {CH{EDGE_RISE}},
    parameter int            CNT_W       = 8
) (
    input  logic                bclk,
    input  logic                async_rst,
    input  logic [CH-1:0]       async_in,
    input  logic [CH-1:0]       ack,
`ifdef ASYNC_EVT_CNT_EN
    input  logic [CH-1:0]       cnt_clr,
    output logic [CH*CNT_W-1:0] evt_cnt,
`endif
    output logic [CH-1:0]       evt_pulse,
    output logic [CH-1:0]       evt_pend,
    output logic [CH-1:0]       evt_ovf
);

    if (SYNC_STAGES < ASYNC_EVT_MIN_SYNC) begin : g_bad_sync
        $error("async_evt_sync: SYNC_STAGES below ASYNC_EVT_MIN_SYNC");
    end

    if (CH < 1) begin : g_bad_ch
        $error("async_evt_sync: CH must be at least 1");
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_chan
        async_evt_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_SEL    (EDGE_SEL[gi]),
            .CNT_W       (CNT_W)
        ) u_chan (
            .bclk_i      (bclk),
            .async_rst_i (async_rst),
            .async_in_i  (async_in[gi]),
            .ack_i       (ack[gi]),
`ifdef ASYNC_EVT_CNT_EN
            .cnt_clr_i   (cnt_clr[gi]),
            .evt_cnt_o   (evt_cnt[gi*CNT_W +: CNT_W]),
`endif
            .evt_pulse_o (evt_pulse[gi]),
            .evt_pend_o  (evt_pend[gi]),
            .evt_ovf_o   (evt_ovf[gi])
        );
    end

endmodule : async_evt_sync
`default_nettype wire
